// File: rtl/dma_wr_if.sv
// Stream-in / memory-write bus of the write-side DMA.
// The DMA takes the master modport; the upstream producer and the memory take slave.
interface dma_wr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    input  in_valid, in_data, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dma_wr.sv
// Write-side DMA: buffers a stream of result words in a small FIFO and writes them to consecutive
// addresses. Defining DMA_WR_ERR_EN stops a transfer with a sticky err on address overflow.
module dma_wr #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  dma_wr_if.master          bus,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_in_q, rem_in_d;
  logic [LEN_W-1:0]  rem_out_q, rem_out_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic              in_ready_s, mem_we_s, push_s, pop_s;
`ifdef DMA_WR_ERR_EN
  logic              err_q, err_d;
`endif

  // Next-state, FIFO bookkeeping and handshake decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_in_d   = rem_in_q;
    rem_out_d  = rem_out_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
    in_ready_s = 1'b0;
    mem_we_s   = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
`ifdef DMA_WR_ERR_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          rem_in_d  = len;
          rem_out_d = len;
          wptr_d    = '0;
          rptr_d    = '0;
          count_d   = '0;
`ifdef DMA_WR_ERR_EN
          err_d     = 1'b0;
`endif
          state_d   = (len == '0) ? S_DONE : S_RUN;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_RUN: begin
        // Registered count only: a slot freed by this cycle's pop is reused next cycle.
        in_ready_s = (count_q < CNT_W'(FIFO_DEPTH)) && (rem_in_q != '0);
        mem_we_s   = (count_q != '0);
        push_s     = bus.in_valid && in_ready_s;
        pop_s      = mem_we_s && bus.mem_ack;
        if (push_s) begin
          fifo_d[wptr_q] = bus.in_data;
          wptr_d         = wptr_q + PTR_W'(1);
          rem_in_d       = rem_in_q - LEN_W'(1);
        end else begin
          wptr_d         = wptr_q;
        end
        if (pop_s) begin
          rptr_d    = rptr_q + PTR_W'(1);
          addr_d    = addr_q + ADDR_W'(1);
          rem_out_d = rem_out_q - LEN_W'(1);
          if (rem_out_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          rptr_d    = rptr_q;
        end
        case ({push_s, pop_s})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
`ifdef DMA_WR_ERR_EN
        // The write to the all-ones address was the last legal one; abandon the rest.
        if (pop_s && (addr_q == '1) && (rem_out_q > LEN_W'(1))) begin
          err_d   = 1'b1;
          wptr_d  = '0;
          rptr_d  = '0;
          count_d = '0;
          state_d = S_DONE;
        end else begin
          err_d   = err_q;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and FIFO storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_in_q  <= '0;
      rem_out_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_in_q  <= rem_in_d;
      rem_out_q <= rem_out_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef DMA_WR_ERR_EN
  // Sticky overflow flag, cleared by reset or the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_we_s ? fifo_q[rptr_q] : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_dma_wr.sv
// Directed bench for dma_wr: monitors every memory write and accepted input word at the falling edge.
module tb_dma_wr;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = 16'h0000;
  logic [LW-1:0] len = 16'h0000;
  logic          busy, done, err;
  int            checks = 0;
  int            failures = 0;

  dma_wr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dma_wr #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .bus(bus.master), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [DW-1:0] acc[$];
  int            done_cnt = 0;
  int            rdy_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ack) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_data);
    if (done) done_cnt++;
    if (bus.in_ready) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] n);
    start = 1'b1;
    start_addr = a;
    len = n;
    tick();
    start = 1'b0;
  endtask

  // Feeds words base, base+1, ... until done is seen; vmode/amode 1 randomise in_valid/mem_ack.
  task automatic drive(input int n, input logic [DW-1:0] base, input int vmode, input int amode,
                       input int rp, output bit to);
    int idx = 0;
    int cyc = 0;
    to = 1'b1;
    while (cyc < 400) begin
      bus.in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_data  = (idx < n) ? base + DW'(idx) : 16'hDEAD;
      bus.mem_ack  = (amode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc == rp) begin
        start = 1'b1;
        start_addr = 16'h5555;
        len = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        to = 1'b0;
        break;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      cyc++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ack = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.in_ready, bus.mem_we, busy, done, err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {bus.in_ready, bus.mem_we, busy, done, err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=00000000", {bus.mem_addr, bus.mem_wdata});
    end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int sw = wa.size();
    int sa = acc.size();
    int sd = done_cnt;
    bit to;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    do_start(16'h0100, 16'd4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b exp=1", busy);
    end
    drive(4, 16'h00A1, 0, 0, -1, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL basic_timeout got=timeout exp=done");
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after got=%b exp=00", {busy, done});
    end
    checks++;
    if (wa.size() - sw != 4 || acc.size() - sa != 4 || done_cnt - sd != 1) begin
      failures++;
      $display("FAIL basic_counts got=%0d/%0d/%0d exp=4/4/1", wa.size() - sw, acc.size() - sa,
               done_cnt - sd);
    end
    for (int i = 0; i < 4; i++) begin
      ga = (sw + i < wa.size()) ? wa[sw + i] : 16'hxxxx;
      gd = (sw + i < wd.size()) ? wd[sw + i] : 16'hxxxx;
      checks++;
      if (ga !== 16'h0100 + AW'(i) || gd !== 16'h00A1 + DW'(i)) begin
        failures++;
        $display("FAIL basic_write%0d got=%h:%h exp=%h:%h", i, ga, gd, 16'h0100 + AW'(i),
                 16'h00A1 + DW'(i));
      end
    end
  endtask

  task automatic test_stall();
    int sw = wa.size();
    int sa = acc.size();
    bit to;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    do_start(16'h0120, 16'd8);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = (k < 4) ? 16'h00B1 + DW'(k) : 16'hBEEF;
      bus.mem_ack = 1'b0;
      if (k >= 1) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h0120, 16'h00B1}) begin
          failures++;
          $display("FAIL stall_hold%0d got=%b:%h:%h exp=1:0120:00b1", k, bus.mem_we,
                   bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 5) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_ready got=%b exp=0", bus.in_ready);
        end
      end
      tick();
    end
    checks++;
    if (acc.size() - sa != 4) begin
      failures++;
      $display("FAIL stall_pushes got=%0d exp=4", acc.size() - sa);
    end
    drive(4, 16'h00B5, 0, 0, -1, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL stall_timeout got=timeout exp=done");
    end
    tick();
    checks++;
    if (wa.size() - sw != 8) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=8", wa.size() - sw);
    end
    for (int i = 0; i < 8; i++) begin
      ga = (sw + i < wa.size()) ? wa[sw + i] : 16'hxxxx;
      gd = (sw + i < wd.size()) ? wd[sw + i] : 16'hxxxx;
      checks++;
      if (ga !== 16'h0120 + AW'(i) || gd !== 16'h00B1 + DW'(i)) begin
        failures++;
        $display("FAIL stall_write%0d got=%h:%h exp=%h:%h", i, ga, gd, 16'h0120 + AW'(i),
                 16'h00B1 + DW'(i));
      end
    end
  endtask

  task automatic test_len_zero();
    int sw = wa.size();
    int sr = rdy_cnt;
    int sd = done_cnt;
    bus.in_valid = 1'b1;
    do_start(16'h0300, 16'd0);
    checks++;
    if ({done, busy, bus.mem_we, bus.in_ready} !== 4'b1100) begin
      failures++;
      $display("FAIL len0_done got=%b exp=1100", {done, busy, bus.mem_we, bus.in_ready});
    end
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wa.size() != sw || rdy_cnt != sr || done_cnt - sd != 1) begin
      failures++;
      $display("FAIL len0_after got=%b%b w%0d r%0d d%0d exp=00 w0 r0 d1", done, busy,
               wa.size() - sw, rdy_cnt - sr, done_cnt - sd);
    end
  endtask

  task automatic test_wrap();
    int sw = wa.size();
    bit to;
    int nexp;
    logic [AW-1:0] ea;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    do_start(16'hFFFE, 16'd3);
    drive(3, 16'h00C1, 0, 0, -1, to);
`ifdef DMA_WR_ERR_EN
    nexp = 2;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err got=%b exp=1", err);
    end
`else
    nexp = 3;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err got=%b exp=0", err);
    end
`endif
    checks++;
    if (to) begin
      failures++;
      $display("FAIL wrap_timeout got=timeout exp=done");
    end
    tick();
    checks++;
    if (wa.size() - sw != nexp) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d", wa.size() - sw, nexp);
    end
    for (int i = 0; i < nexp; i++) begin
      ea = 16'hFFFE + AW'(i);
      ga = (sw + i < wa.size()) ? wa[sw + i] : 16'hxxxx;
      gd = (sw + i < wd.size()) ? wd[sw + i] : 16'hxxxx;
      checks++;
      if (ga !== ea || gd !== 16'h00C1 + DW'(i)) begin
        failures++;
        $display("FAIL wrap_write%0d got=%h:%h exp=%h:%h", i, ga, gd, ea, 16'h00C1 + DW'(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    int sw = wa.size();
    int cyc = 0;
    int sr;
    bit to;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    do_start(16'h0400, 16'd6);
    bus.in_valid = 1'b1;
    bus.mem_ack = 1'b1;
    while (wa.size() - sw < 2 && cyc < 50) begin
      bus.in_data = 16'h00D0 + DW'(cyc);
      tick();
      cyc++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.mem_we, busy, done, err, bus.mem_addr, bus.mem_wdata} !== 37'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b%b%b%b%b:%h:%h exp=00000:0000:0000", bus.in_ready,
               bus.mem_we, busy, done, err, bus.mem_addr, bus.mem_wdata);
    end
    sr = wa.size();
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++;
    if (wa.size() != sr) begin
      failures++;
      $display("FAIL midrst_nowrite got=%0d exp=0", wa.size() - sr);
    end
    do_start(16'h0200, 16'd2);
    drive(2, 16'h00D8, 0, 0, -1, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midrst_timeout got=timeout exp=done");
    end
    tick();
    checks++;
    if (wa.size() - sr != 2) begin
      failures++;
      $display("FAIL midrst_count got=%0d exp=2", wa.size() - sr);
    end
    for (int i = 0; i < 2; i++) begin
      ga = (sr + i < wa.size()) ? wa[sr + i] : 16'hxxxx;
      gd = (sr + i < wd.size()) ? wd[sr + i] : 16'hxxxx;
      checks++;
      if (ga !== 16'h0200 + AW'(i) || gd !== 16'h00D8 + DW'(i)) begin
        failures++;
        $display("FAIL midrst_write%0d got=%h:%h exp=%h:%h", i, ga, gd, 16'h0200 + AW'(i),
                 16'h00D8 + DW'(i));
      end
    end
  endtask

  task automatic test_random();
    int sw = wa.size();
    int sa = acc.size();
    int sd = done_cnt;
    bit to;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    do_start(16'h0700, 16'd10);
    drive(10, 16'h00E0, 1, 1, 3, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL rand_timeout got=timeout exp=done");
    end
    tick();
    checks++;
    if (wa.size() - sw != 10 || acc.size() - sa != 10 || done_cnt - sd != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_counts got=%0d/%0d/%0d/%b exp=10/10/1/0", wa.size() - sw,
               acc.size() - sa, done_cnt - sd, busy);
    end
    for (int i = 0; i < 10; i++) begin
      ga = (sw + i < wa.size()) ? wa[sw + i] : 16'hxxxx;
      gd = (sw + i < wd.size()) ? wd[sw + i] : 16'hxxxx;
      checks++;
      if (ga !== 16'h0700 + AW'(i) || gd !== 16'h00E0 + DW'(i)) begin
        failures++;
        $display("FAIL rand_write%0d got=%h:%h exp=%h:%h", i, ga, gd, 16'h0700 + AW'(i),
                 16'h00E0 + DW'(i));
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.mem_ack = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_len_zero();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
